lcd_frame_streamer: RTL and testbench
=====================================

# lcd_frame_streamer

Frame buffer and command sequencer that sits directly upstream of the character LCD controller. It holds a 2×16 character frame written by system logic. On request, it streams the frame to the LCD controller as a sequence of {RS, byte} beats over a valid/ready handshake: line-0 address command, 16 characters, line-1 address command, 16 characters. The LCD controller owns the E-strobe timing and init sequence; this block owns content and ordering only.

## Interface
- `CHARS_PER_LINE`, default 16: characters per line; fixed at 16 in this revision, used for index widths.
- `LINE0_ADDR`, default 8'h80: set-DDRAM-address command for line 0.
- `LINE1_ADDR`, default 8'hC0: set-DDRAM-address command for line 1.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: write strobe into the frame buffer.
- `wr_addr`  in  5: position; [4] is the line, [3:0] is the column.
- `wr_char`  in  8: ASCII/CGROM code.
- `refresh`  in  1: one-cycle request to stream the frame.
- `out_valid`  out  1: beat available.
- `out_ready`  in  1: the LCD controller accepts the beat.
- `out_rs`  out  1: 0 = command byte, 1 = character byte.
- `out_data`  out  8: beat payload.
- `busy`  out  1: a frame is in progress.
- `frame_done`  out  1: one-cycle pulse after the last beat is accepted.

## Operation
- Frame buffer: 32×8 registers, written whenever `wr_en` = 1, in every state.
- State machine, with `idx` a 4-bit column counter:
  - `IDLE`: `out_valid`=0. Leave on `refresh` or a pending request.
  - `ADDR0`: emit {0, `LINE0_ADDR`}.
  - `LINE0`: emit {1, buf[{0,idx}]} for idx 0..15.
  - `ADDR1`: emit {0, `LINE1_ADDR`}.
  - `LINE1`: emit {1, buf[{1,idx}]} for idx 0..15.
  - After the last `LINE1` beat is accepted: go to `IDLE`, or directly to `ADDR0` if a request is pending.
- Beat advance only when `out_valid && out_ready`. `idx` clears on entering `LINE0`/`LINE1` and wraps 15→0 on exit.
- `out_data` and `out_rs` are registered and loaded from the buffer when a beat is loaded. They hold stable while `out_valid && !out_ready`.
- Pending request (1-bit flag):
  - Set by `refresh` while `busy`.
  - Cleared when a new frame starts.
  - Multiple requests collapse to one.
- Same-cycle write and beat load to the same address: the beat carries the old value, and the write lands in the buffer.
- `busy` = (state ≠ `IDLE`).

## Timing
- Reset values:
  - state `IDLE`, `out_valid`=0, `out_rs`=0, `out_data`=8'h00, `busy`=0, `frame_done`=0.
  - Pending flag cleared.
  - All 32 buffer entries set to 8'h20 (space).
- `refresh` at cycle N in `IDLE` → `out_valid`=1 with {0, 8'h80} at N+1.
- With `out_ready` held high: one beat per cycle, 34 beats, last accepted at N+34, `frame_done`=1 and `busy`=0 at N+35.
- Back-to-back frames (request pending): `ADDR0` beat valid at N+35, no `IDLE` cycle; `busy` stays 1 and `frame_done` still pulses.
- `out_valid` never deasserts without acceptance while in a beat state.
- Reset asserted mid-frame: all outputs return to reset values immediately. The buffer is cleared to spaces and no partial frame resumes.

## Configuration
- `LCD_AUTO_REFRESH_EN`:
  - Defined: every `wr_en` also acts as a refresh request. In `IDLE` it starts a frame next cycle; while `busy` it sets pending, so the final displayed frame always reflects the last write.
  - Undefined: frames start only on `refresh`; writes never trigger streaming.

## Structure
- Shared package `lcd_pkg`:
  - `lcd_beat_t` packed struct {rs, data[7:0]}.
  - State enum `lcd_stream_state_t`.
  - Constants `LCD_CMD_LINE0` (8'h80), `LCD_CMD_LINE1` (8'hC0), `LCD_CHAR_SPACE` (8'h20).
- One sub-module: `lcd_frame_ram`, the 32×8 register array with async-reset-to-space, a write port and a combinational read port.
- Sequencer and handshake live in the top.

## Test plan
- Reset → `out_valid`=0, `busy`=0. `refresh` streams {0,80}, 16×{1,20}, {0,C0}, 16×{1,20}; `frame_done` pulses at beat 34 + 1 cycle.
- Write "HELLO" at addr 0–4 and 'Z' at addr 31, then `refresh` with `out_ready`=1 → beats 2–6 = 48,45,4C,4C,4F; beat 34 = {1,5A}.
- `out_ready` toggled 1/0 every cycle → 34 beats in 68 cycles. `out_data` is unchanged during every stalled cycle.
- `refresh` pulsed twice mid-frame → exactly one extra frame, no `IDLE` gap, two `frame_done` pulses total.
- Reset asserted at beat 10 → `out_valid` drops asynchronously. After release, `refresh` yields an all-space frame.
- `LCD_AUTO_REFRESH_EN` defined: single write of 8'h41 at addr 16 in `IDLE` → frame starts next cycle, beat 19 = {1,41}. Undefined: no beats.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame streamer.
// Beat encoding, sequencer states and the HD44780-style command bytes.
package lcd_pkg;

    localparam int         LCD_DEPTH      = 32;
    localparam int         LCD_ADDR_W     = 5;
    localparam logic [7:0] LCD_CMD_LINE0  = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1  = 8'hC0;
    localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_beat_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR0,
        LINE0,
        ADDR1,
        LINE1
    } lcd_stream_state_t;

endpackage

// File: rtl/lcd_frame_ram.sv
// 32x8 character frame buffer: async reset to spaces, one write port,
// one combinational read port (a same-cycle write is seen only after the edge).
module lcd_frame_ram
    import lcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [LCD_ADDR_W-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [LCD_ADDR_W-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [LCD_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LCD_DEPTH; i++) begin
                mem[i] <= LCD_CHAR_SPACE;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams a 2x16 character frame to the LCD controller as {rs, byte} beats.
// Build option LCD_AUTO_REFRESH_EN: every buffer write also requests a refresh.
module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int         CHARS_PER_LINE = 16,
    parameter logic [7:0] LINE0_ADDR     = LCD_CMD_LINE0,
    parameter logic [7:0] LINE1_ADDR     = LCD_CMD_LINE1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       refresh,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int               IDX_W    = $clog2(CHARS_PER_LINE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS_PER_LINE - 1);

    lcd_stream_state_t state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    lcd_beat_t         beat, beat_nxt;
    logic              pending, pending_nxt;
    logic              done_nxt;
    logic              req;
    logic              accept;
    logic              rd_line;
    logic [IDX_W-1:0]  rd_col;
    logic [7:0]        rd_data;

`ifdef LCD_AUTO_REFRESH_EN
    assign req = refresh | wr_en;
`else
    assign req = refresh;
`endif

    assign out_valid = (state != IDLE);
    assign busy      = out_valid;
    assign accept    = out_valid && out_ready;
    assign out_rs    = beat.rs;
    assign out_data  = beat.data;

    // Read address is the character that follows the beat currently presented.
    assign rd_line = (state == ADDR1) || (state == LINE1);
    assign rd_col  = ((state == LINE0) || (state == LINE1)) ? idx + IDX_W'(1) : '0;

    lcd_frame_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_char),
        .rd_addr ({rd_line, rd_col}),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            beat       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            beat       <= beat_nxt;
            pending    <= pending_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        beat_nxt    = beat;
        pending_nxt = pending | (req && busy);
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (req || pending) begin
                    state_nxt   = ADDR0;
                    beat_nxt    = '{rs: 1'b0, data: LINE0_ADDR};
                    pending_nxt = 1'b0;
                end
            end
            ADDR0: begin
                if (accept) begin
                    state_nxt = LINE0;
                    idx_nxt   = '0;
                    beat_nxt  = '{rs: 1'b1, data: rd_data};
                end
            end
            LINE0: begin
                if (accept) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = ADDR1;
                        idx_nxt   = '0;
                        beat_nxt  = '{rs: 1'b0, data: LINE1_ADDR};
                    end else begin
                        idx_nxt  = idx + IDX_W'(1);
                        beat_nxt = '{rs: 1'b1, data: rd_data};
                    end
                end
            end
            ADDR1: begin
                if (accept) begin
                    state_nxt = LINE1;
                    idx_nxt   = '0;
                    beat_nxt  = '{rs: 1'b1, data: rd_data};
                end
            end
            LINE1: begin
                if (accept) begin
                    if (idx == IDX_LAST) begin
                        done_nxt = 1'b1;
                        idx_nxt  = '0;
                        // A request seen during this frame restarts without an idle gap.
                        if (pending_nxt) begin
                            state_nxt   = ADDR0;
                            beat_nxt    = '{rs: 1'b0, data: LINE0_ADDR};
                            pending_nxt = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt  = idx + IDX_W'(1);
                        beat_nxt = '{rs: 1'b1, data: rd_data};
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Self-checking bench for lcd_frame_streamer: table vectors, timed corner
// sequences and randomized frames against a shadow-buffer frame model.
module tb_lcd_frame_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_char;
    logic       refresh;
    logic       out_valid;
    logic       out_ready;
    logic       out_rs;
    logic [7:0] out_data;
    logic       busy;
    logic       frame_done;

    lcd_frame_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .refresh    (refresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rs     (out_rs),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #10 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] shadow [32];
    logic [8:0] exp_f  [34];
    logic [8:0] acc_q  [$];
    int         fd_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_beat = '0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] ch;
        int         beat_no;
        logic [8:0] exp_beat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Beat monitor: records accepted beats, frame_done pulses, stall stability.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (stall_prev && out_valid)
                check("stall_hold", {out_rs, out_data}, stall_beat);
            if (out_valid && out_ready)
                acc_q.push_back({out_rs, out_data});
            if (frame_done)
                fd_cnt++;
            stall_prev = out_valid && !out_ready;
            stall_beat = {out_rs, out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp;
        exp_f[0]  = 9'h080;
        exp_f[17] = 9'h0C0;
        for (int c = 0; c < 16; c++) begin
            exp_f[1 + c]  = {1'b1, shadow[c]};
            exp_f[18 + c] = {1'b1, shadow[16 + c]};
        end
    endtask

    task automatic cmp_frame(input string name, input int base);
        build_exp();
        for (int k = 0; k < 34; k++)
            check(name, acc_q[base + k], exp_f[k]);
    endtask

    task automatic write(input logic [4:0] a, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_char = c;
        tick();
        wr_en     = 1'b0;
        shadow[a] = c;
    endtask

    task automatic drain;
        int n;
        n         = 0;
        out_ready = 1'b1;
        refresh   = 1'b0;
        wr_en     = 1'b0;
        tick();
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (busy) fail_timeout("drain");
        tick();
        acc_q.delete();
        fd_cnt = 0;
    endtask

    task automatic do_refresh;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    // Called in cycle N+1 after a refresh at N; returns the cycle offset of frame_done.
    task automatic wait_done(input int mode, input int budget, output int cyc);
        cyc = 1;
        while (!frame_done && cyc < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            tick();
            cyc++;
        end
        if (!frame_done) fail_timeout("frame_done_wait");
        out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  gap;

        vecs[0] = '{5'd0,  8'h48, 2,  9'h148};
        vecs[1] = '{5'd1,  8'h45, 3,  9'h145};
        vecs[2] = '{5'd2,  8'h4C, 4,  9'h14C};
        vecs[3] = '{5'd3,  8'h4C, 5,  9'h14C};
        vecs[4] = '{5'd4,  8'h4F, 6,  9'h14F};
        vecs[5] = '{5'd31, 8'h5A, 34, 9'h15A};

        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
        refresh = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_beat", {out_rs, out_data}, 9'h000);
        rst = 1'b1;
        tick(); tick();
        check("idle_valid", out_valid, 1'b0);

        // Plain all-space frame with ready held high
        acc_q.delete(); fd_cnt = 0;
        do_refresh();
        check("first_beat", {out_valid, out_rs, out_data}, 10'h280);
        check("first_busy", busy, 1'b1);
        wait_done(0, 100, cyc);
        check("done_cycle", cyc, 35);
        check("done_busy", busy, 1'b0);
        tick();
        check("beat_count", acc_q.size(), 34);
        if (acc_q.size() == 34) cmp_frame("space_frame", 0);
        check("done_pulses", fd_cnt, 1);
        check("done_one_cycle", frame_done, 1'b0);

        // Table: HELLO on line 0, Z in the last cell
        for (int v = 0; v < 6; v++) write(vecs[v].addr, vecs[v].ch);
        drain();
        do_refresh();
        wait_done(0, 100, cyc);
        tick();
        check("hello_count", acc_q.size(), 34);
        if (acc_q.size() == 34) begin
            for (int v = 0; v < 6; v++)
                check($sformatf("hello_beat%0d", vecs[v].beat_no),
                      acc_q[vecs[v].beat_no - 1], vecs[v].exp_beat);
            cmp_frame("hello_frame", 0);
        end

        // Ready toggling every cycle: 34 beats over 68 cycles
        drain();
        do_refresh();
        wait_done(1, 200, cyc);
        check("toggle_done_cycle", cyc, 69);
        tick();
        check("toggle_count", acc_q.size(), 34);
        if (acc_q.size() == 34) cmp_frame("toggle_frame", 0);

        // Two refreshes mid-frame collapse to one back-to-back frame
        drain();
        do_refresh();
        gap = 1'b0;
        for (cyc = 1; cyc <= 70; cyc++) begin
            refresh = (cyc == 5 || cyc == 12);
            if (cyc <= 68 && !busy) gap = 1'b1;
            if (cyc == 35) begin
                check("b2b_addr0", {out_valid, out_rs, out_data}, 10'h280);
                check("b2b_done1", frame_done, 1'b1);
            end
            if (cyc == 69) begin
                check("b2b_done2", frame_done, 1'b1);
                check("b2b_idle", busy, 1'b0);
            end
            tick();
        end
        refresh = 1'b0;
        check("b2b_no_gap", gap, 1'b0);
        check("b2b_pulses", fd_cnt, 2);
        check("b2b_count", acc_q.size(), 68);
        if (acc_q.size() == 68) begin
            cmp_frame("b2b_frame1", 0);
            cmp_frame("b2b_frame2", 34);
        end

        // Reset at beat 10 drops everything and clears the buffer
        drain();
        do_refresh();
        for (cyc = 1; cyc < 10; cyc++) tick();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_beat", {out_rs, out_data}, 9'h000);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        tick();
        check("post_rst_idle", out_valid, 1'b0);
        acc_q.delete(); fd_cnt = 0;
        do_refresh();
        wait_done(0, 100, cyc);
        tick();
        check("post_rst_count", acc_q.size(), 34);
        if (acc_q.size() == 34) cmp_frame("post_rst_frame", 0);

        // Randomized contents and backpressure
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++)
                write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            drain();
            do_refresh();
            wait_done(2, 400, cyc);
            tick();
            check("rand_count", acc_q.size(), 34);
            check("rand_pulses", fd_cnt, 1);
            if (acc_q.size() == 34) cmp_frame("rand_frame", 0);
        end

        // Write-triggered streaming depends on the build option
        drain();
        write(5'd16, 8'h41);
`ifdef LCD_AUTO_REFRESH_EN
        check("auto_start", {out_valid, out_rs, out_data}, 10'h280);
        wait_done(0, 100, cyc);
        tick();
        check("auto_count", acc_q.size(), 34);
        if (acc_q.size() == 34) check("auto_beat19", acc_q[18], 9'h141);
`else
        for (int i = 0; i < 40; i++) tick();
        check("noauto_beats", acc_q.size(), 0);
        check("noauto_busy", busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
